// File: rtl/ecall_handler.sv
// Environment-call service unit: freezes the pipeline while a PRINT_INT, READ_INT
// or EXIT service interacts with the board's display, switches and push-button.
module ecall_handler #(
  parameter int DATA_W   = 32,
  parameter int SW_W     = 16,
  parameter int SIGN_EXT = 1,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ecall_valid,
  input  logic [11:0]       ecall_code,
  input  logic [DATA_W-1:0] a0_val,
  input  logic              confirm,
  input  logic [SW_W-1:0]   switches,
  output logic              stall,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              input_req,
  output logic              wb_en,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted,
  output logic              err
);

  // state      | meaning
  // IDLE       | no service active, ecalls accepted
  // PRINT_WAIT | value shown, waiting for hold time and a confirm edge
  // READ_WAIT  | waiting for a confirm edge to sample the switches
  // WB         | one-cycle write-back of the sampled value to a0
  // HALT       | program exited, left only by reset

  localparam logic [11:0] SVC_PRINT = 12'd1;
  localparam logic [11:0] SVC_READ  = 12'd5;
  localparam logic [11:0] SVC_EXIT  = 12'd10;
  localparam int          CNT_W     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [2:0] {IDLE, PRINT_WAIT, READ_WAIT, WB, HALT} state_t;

  state_t            state, state_nxt;
  logic              conf_s1, conf_s2, conf_s3;
  logic              conf_rise;
  logic [SW_W-1:0]   sw_s1, sw_s2;
  logic [CNT_W-1:0]  hold_cnt;
  logic [DATA_W-1:0] sw_ext;

  // Third flop only remembers the previous synchronised level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conf_s1 <= 1'b0;
      conf_s2 <= 1'b0;
      conf_s3 <= 1'b0;
      sw_s1   <= '0;
      sw_s2   <= '0;
    end else begin
      conf_s1 <= confirm;
      conf_s2 <= conf_s1;
      conf_s3 <= conf_s2;
      sw_s1   <= switches;
      sw_s2   <= sw_s1;
    end
  end

  assign conf_rise = conf_s2 & ~conf_s3;

  always_comb begin
    sw_ext = ((SIGN_EXT != 0) && sw_s2[SW_W-1]) ? '1 : '0;
    sw_ext[SW_W-1:0] = sw_s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    err       = 1'b0;
    input_req = 1'b0;
    wb_en     = 1'b0;
    halted    = 1'b0;
    case (state)
      IDLE: begin
        if (ecall_valid) begin
          case (ecall_code)
            SVC_PRINT: begin stall = 1'b1; state_nxt = PRINT_WAIT; end
            SVC_READ:  begin stall = 1'b1; state_nxt = READ_WAIT;  end
            SVC_EXIT:  begin stall = 1'b1; state_nxt = HALT;       end
            default:   err = 1'b1;
          endcase
        end
      end
      PRINT_WAIT: begin
        stall = 1'b1;
        if (conf_rise && hold_cnt == '0) state_nxt = IDLE;
      end
      READ_WAIT: begin
        stall     = 1'b1;
        input_req = 1'b1;
        if (conf_rise) state_nxt = WB;
      end
      WB: begin
        stall     = 1'b1;
        wb_en     = 1'b1;
        state_nxt = IDLE;
      end
      HALT: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Display contents persist across services until the next PRINT_INT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_data  <= '0;
      disp_valid <= 1'b0;
      hold_cnt   <= '0;
      wb_data    <= '0;
    end else begin
      if (state == IDLE && ecall_valid && ecall_code == SVC_PRINT) begin
        disp_data  <= a0_val;
        disp_valid <= 1'b1;
        hold_cnt   <= CNT_W'(HOLD_CYC - 1);
      end else if (state == PRINT_WAIT && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - CNT_W'(1);
      end
      if (state == READ_WAIT && conf_rise) wb_data <= sw_ext;
    end
  end

endmodule

// File: tb/tb_ecall_handler.sv
// Bench for ecall_handler: directed scenarios plus random traffic, all checked
// every cycle against a service-level model of the handler.
module tb_ecall_handler;
  localparam int DW = 32;
  localparam int SW = 16;
  localparam int HC = 4;

  localparam int NONE  = 0;
  localparam int PRINT = 1;
  localparam int READ  = 5;
  localparam int EXIT  = 10;
  localparam int WBK   = -1;

  logic clk = 1'b0;
  logic rst;
  logic ecall_valid;
  logic [11:0] ecall_code;
  logic [DW-1:0] a0_val;
  logic confirm;
  logic [SW-1:0] switches;

  logic stall, disp_valid, input_req, wb_en, halted, err;
  logic [DW-1:0] disp_data, wb_data;
  logic z_stall, z_disp_valid, z_input_req, z_wb_en, z_halted, z_err;
  logic [DW-1:0] z_disp_data, z_wb_data;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ecall_handler #(.DATA_W(DW), .SW_W(SW), .SIGN_EXT(1), .HOLD_CYC(HC)) dut (
    .clk(clk), .rst(rst), .ecall_valid(ecall_valid), .ecall_code(ecall_code),
    .a0_val(a0_val), .confirm(confirm), .switches(switches), .stall(stall),
    .disp_data(disp_data), .disp_valid(disp_valid), .input_req(input_req),
    .wb_en(wb_en), .wb_data(wb_data), .halted(halted), .err(err));

  ecall_handler #(.DATA_W(DW), .SW_W(SW), .SIGN_EXT(0), .HOLD_CYC(HC)) dut_z (
    .clk(clk), .rst(rst), .ecall_valid(ecall_valid), .ecall_code(ecall_code),
    .a0_val(a0_val), .confirm(confirm), .switches(switches), .stall(z_stall),
    .disp_data(z_disp_data), .disp_valid(z_disp_valid), .input_req(z_input_req),
    .wb_en(z_wb_en), .wb_data(z_wb_data), .halted(z_halted), .err(z_err));

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit supported(input logic [11:0] c);
    return (c == 12'd1) || (c == 12'd5) || (c == 12'd10);
  endfunction

  // Service-level model: which service is pending, how long the print must still
  // be shown, and the raw button/switch history seen through two sampling stages.
  int m_svc;
  int m_hold;
  logic [DW-1:0] m_disp, m_wb_s, m_wb_z;
  logic m_dv;
  logic m_c[3];
  logic [SW-1:0] m_sw[2];
  bit m_rise;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_svc = NONE; m_hold = 0; m_disp = '0; m_dv = 1'b0; m_wb_s = '0; m_wb_z = '0;
      m_c[0] = 1'b0; m_c[1] = 1'b0; m_c[2] = 1'b0; m_sw[0] = '0; m_sw[1] = '0;
    end else begin
      m_rise = m_c[1] && !m_c[2];
      case (m_svc)
        NONE: if (ecall_valid) begin
          if (ecall_code == 12'd1) begin
            m_disp = a0_val; m_dv = 1'b1; m_hold = HC - 1; m_svc = PRINT;
          end else if (ecall_code == 12'd5) m_svc = READ;
          else if (ecall_code == 12'd10) m_svc = EXIT;
        end
        PRINT: begin
          if (m_rise && m_hold == 0) m_svc = NONE;
          else if (m_hold > 0) m_hold--;
        end
        READ: if (m_rise) begin
          m_wb_s = {{(DW-SW){m_sw[1][SW-1]}}, m_sw[1]};
          m_wb_z = {{(DW-SW){1'b0}}, m_sw[1]};
          m_svc = WBK;
        end
        WBK: m_svc = NONE;
        default: ;
      endcase
      m_c[2] = m_c[1]; m_c[1] = m_c[0]; m_c[0] = confirm;
      m_sw[1] = m_sw[0]; m_sw[0] = switches;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", stall, (m_svc != NONE) || (m_svc == NONE && ecall_valid && supported(ecall_code)));
      cmp("err", err, m_svc == NONE && ecall_valid && !supported(ecall_code));
      cmp("input_req", input_req, m_svc == READ);
      cmp("wb_en", wb_en, m_svc == WBK);
      cmp("halted", halted, m_svc == EXIT);
      cmp("disp_valid", disp_valid, m_dv);
      cmp("disp_data", disp_data, m_disp);
      cmp("wb_data", wb_data, m_wb_s);
      cmp("wb_en_z", z_wb_en, m_svc == WBK);
      cmp("wb_data_z", z_wb_data, m_wb_z);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses, bad, r;
    rst = 1'b1; ecall_valid = 1'b0; ecall_code = '0; a0_val = '0; confirm = 1'b0; switches = '0;
    step(3);
    chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_stall", stall, 0);
    cmp("rst_disp_valid", disp_valid, 0);
    step(1); rst = 1'b0;

    // PRINT_INT: early confirm ignored, later confirm releases after sync latency
    step(1); ecall_valid = 1'b1; ecall_code = 12'd1; a0_val = 32'h0000_002A;
    @(negedge clk); cmp("print_stall_same_cycle", stall, 1);
    step(1); ecall_valid = 1'b0; confirm = 1'b1;
    @(negedge clk); cmp("print_disp_data", disp_data, 32'h2A); cmp("print_disp_valid", disp_valid, 1);
    step(1); confirm = 1'b0;
    step(8); confirm = 1'b1;
    n = 0;
    while (stall && n < 8) begin step(1); n++; end
    cmp("print_release", stall, 0);
    cmp("print_release_cycles", n, 3);
    cmp("print_disp_hold", disp_data, 32'h2A);
    confirm = 1'b0;

    // READ_INT with negative switch value, both extension modes
    step(2); switches = 16'hFFFE; ecall_valid = 1'b1; ecall_code = 12'd5;
    step(1); ecall_valid = 1'b0;
    @(negedge clk); cmp("read_input_req", input_req, 1);
    step(3); confirm = 1'b1;
    n = 0;
    while (!wb_en && n < 10) begin step(1); n++; end
    cmp("read_wb_en", wb_en, 1);
    cmp("read_wb_signed", wb_data, 32'hFFFF_FFFE);
    cmp("read_wb_zero", z_wb_data, 32'h0000_FFFE);
    step(1);
    cmp("read_wb_one_cycle", wb_en, 0);
    cmp("read_stall_after_wb", stall, 0);
    confirm = 1'b0;

    // unsupported code
    step(2); ecall_valid = 1'b1; ecall_code = 12'd7; a0_val = 32'h1234;
    @(negedge clk); cmp("unsup_err", err, 1); cmp("unsup_stall", stall, 0);
    step(1); ecall_valid = 1'b0;
    @(negedge clk);
    cmp("unsup_err_clear", err, 0);
    cmp("unsup_disp_kept", disp_data, 32'h2A);
    cmp("unsup_wb_kept", wb_data, 32'hFFFF_FFFE);

    // held button: one write-back, the next READ waits for a fresh edge
    step(1); ecall_valid = 1'b1; ecall_code = 12'd5; switches = 16'h0123;
    step(1); ecall_valid = 1'b0;
    step(2); confirm = 1'b1;
    pulses = 0;
    repeat (15) begin step(1); if (wb_en) pulses++; end
    cmp("held_first_pulses", pulses, 1);
    ecall_valid = 1'b1; ecall_code = 12'd5;
    step(1); ecall_valid = 1'b0;
    pulses = 0;
    repeat (15) begin step(1); if (wb_en) pulses++; end
    cmp("held_second_waits", pulses, 0);
    cmp("held_second_input_req", input_req, 1);

    // asynchronous reset in the middle of READ_WAIT
    confirm = 1'b0;
    @(negedge clk); #2 rst = 1'b1; #1;
    cmp("arst_input_req", input_req, 0);
    cmp("arst_stall", stall, 0);
    cmp("arst_wb_data", wb_data, 0);
    cmp("arst_disp_data", disp_data, 0);
    cmp("arst_disp_valid", disp_valid, 0);
    step(1); rst = 1'b0;
    step(1); ecall_valid = 1'b1; ecall_code = 12'd5; switches = 16'h8001;
    step(1); ecall_valid = 1'b0;
    step(3); confirm = 1'b1;
    n = 0;
    while (!wb_en && n < 10) begin step(1); n++; end
    cmp("arst_read_wb_en", wb_en, 1);
    cmp("arst_read_wb_data", wb_data, 32'hFFFF_8001);
    confirm = 1'b0;

    // button held high through reset release yields exactly one edge
    step(2); confirm = 1'b1; rst = 1'b1;
    step(2); rst = 1'b0; ecall_valid = 1'b1; ecall_code = 12'd5; switches = 16'h7FFF;
    step(1); ecall_valid = 1'b0;
    pulses = 0;
    repeat (10) begin if (wb_en) pulses++; step(1); end
    cmp("rst_held_one_pulse", pulses, 1);
    cmp("rst_held_wb_data", wb_data, 32'h0000_7FFF);
    ecall_valid = 1'b1; ecall_code = 12'd5;
    step(1); ecall_valid = 1'b0;
    pulses = 0;
    repeat (10) begin step(1); if (wb_en) pulses++; end
    cmp("rst_held_second_waits", pulses, 0);
    confirm = 1'b0; step(2); confirm = 1'b1; step(8); confirm = 1'b0;
    rst = 1'b1; step(1); rst = 1'b0;

    // randomized traffic
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      rst = ($urandom_range(0, 399) == 0) || (bad > 40);
      if (rst) bad = 0;
      else if (halted) bad++;
      ecall_valid = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 99);
      if (r < 35) ecall_code = 12'd1;
      else if (r < 70) ecall_code = 12'd5;
      else if (r < 72) ecall_code = 12'd10;
      else ecall_code = 12'($urandom_range(0, 4095));
      a0_val = $urandom;
      switches = 16'($urandom);
      if ($urandom_range(0, 5) == 0) confirm = ~confirm;
    end
    step(1); rst = 1'b1; ecall_valid = 1'b0; confirm = 1'b0;
    step(1); rst = 1'b0;

    // EXIT holds for 100 cycles regardless of confirm and ecalls
    step(1); ecall_valid = 1'b1; ecall_code = 12'd10;
    step(1);
    bad = 0;
    repeat (100) begin
      ecall_valid = 1'($urandom_range(0, 1));
      ecall_code = 12'($urandom_range(0, 15));
      confirm = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!halted || !stall) bad++;
      step(1);
    end
    cmp("exit_held_100", bad, 0);
    ecall_valid = 1'b0; confirm = 1'b0; rst = 1'b1; #1;
    cmp("exit_rst_halted", halted, 0);
    cmp("exit_rst_stall", stall, 0);
    step(1); rst = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
